// File: rtl/player_draw_pkg.sv
// Shared types and constants for the player overlay stage and its VGA timing bus.
package player_draw_pkg;

    localparam int unsigned HOR_PIXELS  = 1024;
    localparam int unsigned VER_PIXELS  = 768;
    localparam int unsigned COORD_W     = 11;
    localparam int unsigned RGB_W       = 12;
    localparam int unsigned SPRITE_SIZE = 32;
    localparam int unsigned SPR_W       = $clog2(SPRITE_SIZE);
    localparam int unsigned ADDR_W      = 2 * SPR_W;

    localparam logic [RGB_W-1:0] TRANSP_RGB_DEF = 12'hF0F;

    typedef enum logic [1:0] {IDLE, GROUND, RISE, FALL} player_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] vcount;
        logic               vsync;
        logic               vblnk;
        logic [COORD_W-1:0] hcount;
        logic               hsync;
        logic               hblnk;
        logic [RGB_W-1:0]   rgb;
    } vga_timing_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing plus pixel colour passed between overlay stages.
interface vga_if;
    import player_draw_pkg::*;

    logic [COORD_W-1:0] vcount;
    logic               vsync;
    logic               vblnk;
    logic [COORD_W-1:0] hcount;
    logic               hsync;
    logic               hblnk;
    logic [RGB_W-1:0]   rgb;

    modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
    modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/delay.sv
// Generic N-stage register delay line with synchronous active-low clear.
module delay #(
    parameter int unsigned WIDTH   = 1,
    parameter int unsigned CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);
    logic [WIDTH-1:0] stage [CLK_DEL];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < int'(CLK_DEL); i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < int'(CLK_DEL); i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[CLK_DEL-1];
endmodule

// File: rtl/player_draw_ctl.sv
// Player position, jump FSM and frame-tick detection; updates once per frame.
// PLAYER_MIRROR_EN adds the facing register used for horizontal sprite mirroring.
module player_draw_ctl
    import player_draw_pkg::*;
#(
    parameter int unsigned X_START     = 64,
    parameter int unsigned GROUND_Y    = 704,
    parameter int unsigned X_STEP      = 4,
    parameter int unsigned JUMP_STEP   = 6,
    parameter int unsigned JUMP_FRAMES = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_game,
    input  logic               move_left,
    input  logic               move_right,
    input  logic               jump,
    input  logic               vblnk,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output player_state_t      state
`ifdef PLAYER_MIRROR_EN
    ,
    output logic               facing_left
`endif
);
    localparam int unsigned CNT_W = $clog2(JUMP_FRAMES);
    localparam int unsigned EXT_W = COORD_W + 1;
    localparam int unsigned X_MAX = HOR_PIXELS - SPRITE_SIZE;

    player_state_t      state_nxt;
    logic [COORD_W-1:0] x_nxt, y_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [EXT_W-1:0]   x_w, y_w;
    logic               vblnk_q, tick;
`ifdef PLAYER_MIRROR_EN
    logic               facing_nxt;
`endif

    assign tick = vblnk & ~vblnk_q;
    assign x_w  = {1'b0, x};
    assign y_w  = {1'b0, y};

    // Next-state: start_game low overrides everything, otherwise act on frame ticks only.
    always_comb begin
        state_nxt = state;
        x_nxt     = x;
        y_nxt     = y;
        cnt_nxt   = cnt;
`ifdef PLAYER_MIRROR_EN
        facing_nxt = facing_left;
`endif
        if (!start_game) begin
            state_nxt = IDLE;
            x_nxt     = COORD_W'(X_START);
            y_nxt     = COORD_W'(GROUND_Y);
        end else if (tick) begin
            if (state != IDLE) begin
                if (move_left && !move_right) begin
                    x_nxt = (x_w >= EXT_W'(X_STEP)) ? COORD_W'(x_w - EXT_W'(X_STEP)) : '0;
`ifdef PLAYER_MIRROR_EN
                    facing_nxt = 1'b1;
`endif
                end else if (move_right && !move_left) begin
                    x_nxt = (x_w + EXT_W'(X_STEP) <= EXT_W'(X_MAX)) ?
                            COORD_W'(x_w + EXT_W'(X_STEP)) : COORD_W'(X_MAX);
`ifdef PLAYER_MIRROR_EN
                    facing_nxt = 1'b0;
`endif
                end
            end
            case (state)
                IDLE:   state_nxt = GROUND;
                GROUND: begin
                    if (jump) begin
                        state_nxt = RISE;
                        cnt_nxt   = '0;
                    end
                end
                RISE: begin
                    y_nxt = (y_w >= EXT_W'(JUMP_STEP)) ? COORD_W'(y_w - EXT_W'(JUMP_STEP)) : '0;
                    if (cnt == CNT_W'(JUMP_FRAMES - 1)) state_nxt = FALL;
                    else                                cnt_nxt   = cnt + CNT_W'(1);
                end
                FALL: begin
                    if (y_w + EXT_W'(JUMP_STEP) >= EXT_W'(GROUND_Y)) begin
                        y_nxt     = COORD_W'(GROUND_Y);
                        state_nxt = GROUND;
                    end else begin
                        y_nxt = COORD_W'(y_w + EXT_W'(JUMP_STEP));
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            x       <= COORD_W'(X_START);
            y       <= COORD_W'(GROUND_Y);
            cnt     <= '0;
            vblnk_q <= 1'b0;
`ifdef PLAYER_MIRROR_EN
            facing_left <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            x       <= x_nxt;
            y       <= y_nxt;
            cnt     <= cnt_nxt;
            vblnk_q <= vblnk;
`ifdef PLAYER_MIRROR_EN
            facing_left <= facing_nxt;
`endif
        end
    end
endmodule

// File: rtl/player_draw.sv
// Overlays the 32x32 player sprite on the VGA stream with 3-clk latency.
// PLAYER_MIRROR_EN mirrors the sprite horizontally while the player faces left.
module player_draw
    import player_draw_pkg::*;
#(
    parameter int unsigned      X_START     = 64,
    parameter int unsigned      GROUND_Y    = 704,
    parameter int unsigned      X_STEP      = 4,
    parameter int unsigned      JUMP_STEP   = 6,
    parameter int unsigned      JUMP_FRAMES = 16,
    parameter logic [RGB_W-1:0] TRANSP_RGB  = TRANSP_RGB_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_game,
    input  logic              move_left,
    input  logic              move_right,
    input  logic              jump,
    input  logic [RGB_W-1:0]  rgb_pixel,
    output logic [ADDR_W-1:0] pixel_addr,
    vga_if.in                 in,
    vga_if.out                out
);
    localparam int unsigned EXT_W = COORD_W + 1;

    logic [COORD_W-1:0] x, y;
    player_state_t      state;
    logic [EXT_W-1:0]   h_w, v_w, x_w, y_w;
    logic [SPR_W-1:0]   dx_c, dy_c;
    logic               hit_c, hit_q1, hit_q2;
    vga_timing_t        tim_in, tim_d;
`ifdef PLAYER_MIRROR_EN
    logic               facing_left;
`endif

    player_draw_ctl #(
        .X_START     (X_START),
        .GROUND_Y    (GROUND_Y),
        .X_STEP      (X_STEP),
        .JUMP_STEP   (JUMP_STEP),
        .JUMP_FRAMES (JUMP_FRAMES)
    ) u_ctl (
        .clk         (clk),
        .rst         (rst),
        .start_game  (start_game),
        .move_left   (move_left),
        .move_right  (move_right),
        .jump        (jump),
        .vblnk       (in.vblnk),
        .x           (x),
        .y           (y),
        .state       (state)
`ifdef PLAYER_MIRROR_EN
        ,
        .facing_left (facing_left)
`endif
    );

    assign h_w = {1'b0, in.hcount};
    assign v_w = {1'b0, in.vcount};
    assign x_w = {1'b0, x};
    assign y_w = {1'b0, y};

    // Inclusive sprite box test; blanking and IDLE suppress drawing.
    assign hit_c = (state != IDLE) && !in.hblnk && !in.vblnk &&
                   (h_w >= x_w) && (h_w <= x_w + EXT_W'(SPRITE_SIZE - 1)) &&
                   (v_w >= y_w) && (v_w <= y_w + EXT_W'(SPRITE_SIZE - 1));

    assign dy_c = SPR_W'(v_w - y_w);

    always_comb begin
        dx_c = SPR_W'(h_w - x_w);
`ifdef PLAYER_MIRROR_EN
        if (facing_left) dx_c = SPR_W'(SPRITE_SIZE - 1) - dx_c;
`endif
    end

    always_comb begin
        tim_in.vcount = in.vcount;
        tim_in.vsync  = in.vsync;
        tim_in.vblnk  = in.vblnk;
        tim_in.hcount = in.hcount;
        tim_in.hsync  = in.hsync;
        tim_in.hblnk  = in.hblnk;
        tim_in.rgb    = in.rgb;
    end

    delay #(
        .WIDTH   ($bits(vga_timing_t)),
        .CLK_DEL (2)
    ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (tim_in),
        .dout (tim_d)
    );

    // C1: ROM address (held on a miss) and hit flag pipeline.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pixel_addr <= '0;
            hit_q1     <= 1'b0;
            hit_q2     <= 1'b0;
        end else begin
            if (hit_c) pixel_addr <= {dy_c, dx_c};
            hit_q1 <= hit_c;
            hit_q2 <= hit_q1;
        end
    end

    // C3: compose sprite over background, transparent colour lets background through.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out.vcount <= '0;
            out.vsync  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.hcount <= '0;
            out.hsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.vcount <= tim_d.vcount;
            out.vsync  <= tim_d.vsync;
            out.vblnk  <= tim_d.vblnk;
            out.hcount <= tim_d.hcount;
            out.hsync  <= tim_d.hsync;
            out.hblnk  <= tim_d.hblnk;
            out.rgb    <= (hit_q2 && (rgb_pixel != TRANSP_RGB)) ? rgb_pixel : tim_d.rgb;
        end
    end
endmodule
